// File: rtl/rd_data_checker.sv
// Read-side memory checker: rebuilds the expected pattern per Avalon read beat and reports the first mismatching enabled byte.
// Error result 2 cycles after the beat; rd_valid_i is never stalled, commands are throttled by cmd_ready_o.
module rd_data_checker #(
  parameter int AMM_DATA_W  = 128,
  parameter int AMM_BURST_W = 11,
  parameter int DATA_B_W    = AMM_DATA_W / 8,
  parameter int ADDR_B_W    = $clog2(DATA_B_W),
  parameter int ADDR_W      = 32,
  localparam int CMD_W      = 2 + 8 + ADDR_W + AMM_BURST_W + 3 * DATA_B_W
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic [CMD_W-1:0]           cmd_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [AMM_DATA_W-1:0]      rd_data_i,
  input  logic                       rd_valid_i,
  output logic                       err_o,
  output logic                       err_flag_o,
  output logic [ADDR_W+ADDR_B_W-1:0] err_addr_o,
  output logic [7:0]                 err_data_o,
  output logic [7:0]                 err_exp_o,
  output logic                       unexp_o,
  output logic [31:0]                rd_words_o,
  output logic                       busy_o
);

  // cmp_struct_t layout, MSB first; rnd_data selects RND_DATA (1) over FIX_DATA (0).
  typedef struct packed {
    logic                   pkt_type;
    logic                   rnd_data;
    logic [7:0]             data_ptrn;
    logic [ADDR_W-1:0]      word_addr;
    logic [AMM_BURST_W-1:0] word_count;
    logic [DATA_B_W-1:0]    start_mask;
    logic [DATA_B_W-1:0]    end_mask;
    logic [DATA_B_W-1:0]    middle_mask;
  } cmp_struct_t;

  typedef enum logic {ST_IDLE, ST_CHECK} state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  cmp_struct_t w_cmd;
  assign w_cmd = cmd_i;

  state_t                 r_state;
  logic                   r_rnd;
  logic [7:0]             r_ptrn;
  logic [7:0]             r_lfsr;
  logic [ADDR_W-1:0]      r_word_addr;
  logic [AMM_BURST_W-1:0] r_word_cnt;
  logic [AMM_BURST_W-1:0] r_beat_cnt;
  logic [DATA_B_W-1:0]    r_start_mask;
  logic [DATA_B_W-1:0]    r_end_mask;
  logic [DATA_B_W-1:0]    r_mid_mask;

  logic w_beat;
  logic w_last;
  logic w_last_beat;
  logic w_cmd_start;

  assign w_beat      = (r_state == ST_CHECK) && rd_valid_i;
  assign w_last      = (r_beat_cnt == r_word_cnt - AMM_BURST_W'(1));
  assign w_last_beat = w_beat && w_last;
  assign cmd_ready_o = (r_state == ST_IDLE) || w_last_beat;
  assign w_cmd_start = cmd_valid_i && cmd_ready_o && w_cmd.pkt_type &&
                       (w_cmd.word_count != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_rnd        <= 1'b0;
      r_ptrn       <= '0;
      r_lfsr       <= '0;
      r_word_addr  <= '0;
      r_word_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_start_mask <= '0;
      r_end_mask   <= '0;
      r_mid_mask   <= '0;
    end else if (w_cmd_start) begin
      r_state      <= ST_CHECK;
      r_rnd        <= w_cmd.rnd_data;
      r_ptrn       <= w_cmd.data_ptrn;
      r_lfsr       <= (w_cmd.data_ptrn == 8'h00) ? 8'hFF : w_cmd.data_ptrn;
      r_word_addr  <= w_cmd.word_addr;
      r_word_cnt   <= w_cmd.word_count;
      r_beat_cnt   <= '0;
      r_start_mask <= w_cmd.start_mask;
      r_end_mask   <= w_cmd.end_mask;
      r_mid_mask   <= w_cmd.middle_mask;
    end else if (w_last_beat) begin
      r_state <= ST_IDLE;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + AMM_BURST_W'(1);
      r_lfsr     <= lfsr_next(r_lfsr);
    end
  end

  logic [DATA_B_W-1:0] w_mask;
  logic [7:0]          w_exp;

  always_comb begin
    w_mask = r_mid_mask;
    if (r_word_cnt == AMM_BURST_W'(1)) begin
      w_mask = r_start_mask & r_end_mask;
    end else if (r_beat_cnt == '0) begin
      w_mask = r_start_mask;
    end else if (w_last) begin
      w_mask = r_end_mask;
    end
    w_exp = r_rnd ? r_lfsr : r_ptrn;
  end

  logic                  r_s1_vld;
  logic [AMM_DATA_W-1:0] r_s1_data;
  logic [7:0]            r_s1_exp;
  logic [DATA_B_W-1:0]   r_s1_mask;
  logic [ADDR_W-1:0]     r_s1_word;
  logic                  r_s2_vld;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_s1_exp  <= '0;
      r_s1_mask <= '0;
      r_s1_word <= '0;
      r_s2_vld  <= 1'b0;
    end else begin
      r_s1_vld <= w_beat;
      r_s2_vld <= r_s1_vld;
      if (w_beat) begin
        r_s1_data <= rd_data_i;
        r_s1_exp  <= w_exp;
        r_s1_mask <= w_mask;
        r_s1_word <= r_word_addr + ADDR_W'(r_beat_cnt);
      end
    end
  end

  logic                w_found;
  logic [ADDR_B_W-1:0] w_lane;
  logic [7:0]          w_err_byte;
  logic                w_new_err;

  // Scan downwards so the lowest mismatching lane is the one left standing.
  always_comb begin
    w_found    = 1'b0;
    w_lane     = '0;
    w_err_byte = '0;
    for (int j = DATA_B_W - 1; j >= 0; j--) begin
      if (r_s1_mask[j] && (r_s1_data[8*j +: 8] != r_s1_exp)) begin
        w_found    = 1'b1;
        w_lane     = ADDR_B_W'(j);
        w_err_byte = r_s1_data[8*j +: 8];
      end
    end
  end

  logic                       r_err;
  logic                       r_err_flag;
  logic [ADDR_W+ADDR_B_W-1:0] r_err_addr;
  logic [7:0]                 r_err_data;
  logic [7:0]                 r_err_exp;
  logic                       r_unexp;
  logic [31:0]                r_words;

  assign w_new_err = r_s1_vld && w_found && !r_err_flag && !clear_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err      <= 1'b0;
      r_err_flag <= 1'b0;
      r_err_addr <= '0;
      r_err_data <= '0;
      r_err_exp  <= '0;
      r_unexp    <= 1'b0;
      r_words    <= '0;
    end else begin
      r_err <= w_new_err;
      if (clear_i) begin
        r_err_flag <= 1'b0;
        r_err_addr <= '0;
        r_err_data <= '0;
        r_err_exp  <= '0;
        r_unexp    <= 1'b0;
        r_words    <= '0;
      end else begin
        if (w_new_err) begin
          r_err_flag <= 1'b1;
          r_err_addr <= {r_s1_word, w_lane};
          r_err_data <= w_err_byte;
          r_err_exp  <= r_s1_exp;
        end
        if (rd_valid_i && (r_state == ST_IDLE)) begin
          r_unexp <= 1'b1;
        end
        if (w_beat && (r_words != 32'hFFFF_FFFF)) begin
          r_words <= r_words + 32'd1;
        end
      end
    end
  end

  assign err_o      = r_err;
  assign err_flag_o = r_err_flag;
  assign err_addr_o = r_err_addr;
  assign err_data_o = r_err_data;
  assign err_exp_o  = r_err_exp;
  assign unexp_o    = r_unexp;
  assign rd_words_o = r_words;
  assign busy_o     = (r_state == ST_CHECK) || r_s1_vld || r_s2_vld;

endmodule
